piece_fall_ctrl: RTL and testbench
==================================

PIECE_FALL_CTRL -- requirements
Module: piece_fall_ctrl

Interface
REQ-001 SHALL have parameters: X_MIN=240 (pixel x of column 0), Y_MIN=60 (pixel y of row 0), STEP=20 (pixels per cell), COLS=10, ROWS=21, SPAWN_COL=4.
REQ-002 SHALL have ports: clk in 1 system clock; rst in 1 asynchronous active-high reset.
REQ-003 SHALL have ports: spawn_req in 1 new-piece request; spawn_blocked in 1 spawn cell occupied (sampled with spawn_req).
REQ-004 SHALL have ports: tick in 1 gravity pulse, one cycle wide; move_left in 1; move_right in 1; drop in 1 hard-drop request.
REQ-005 SHALL have ports: coll_left in 1, coll_right in 1, coll_below in 1, each meaning the neighbouring cell of the current position is occupied.
REQ-006 SHALL have ports: sq_x out 10 piece pixel x; sq_y out 10 piece pixel y; col out 5 grid column; row out 5 grid row.
REQ-007 SHALL have ports: active out 1 piece falling; lock out 1 one-cycle lock pulse; game_over out 1 sticky.

Function
REQ-008 SHALL use four states: IDLE, FALL, LOCK, OVER.
REQ-009 IDLE: on spawn_req with spawn_blocked=0, SHALL load col=SPAWN_COL, row=0 and enter FALL next cycle.
REQ-010 IDLE: on spawn_req with spawn_blocked=1, SHALL enter OVER; OVER SHALL be left only by rst.
REQ-011 IDLE, LOCK and OVER SHALL ignore tick, move and drop inputs.
REQ-012 FALL: move_left SHALL decrement col by 1 when col>0 and coll_left=0; otherwise col SHALL hold.
REQ-013 FALL: move_right SHALL increment col by 1 when col<COLS-1 and coll_right=0; otherwise col SHALL hold.
REQ-014 FALL: move_left and move_right asserted in the same cycle SHALL produce no lateral move.
REQ-015 FALL: a step event (tick, or drop-mode cycle per REQ-026) with row<ROWS-1 and coll_below=0 SHALL increment row by 1.
REQ-016 FALL: a step event with row=ROWS-1 or coll_below=1 SHALL leave row unchanged and enter LOCK next cycle.
REQ-017 Lateral and vertical updates in the same cycle SHALL both apply; coll_* refer to the pre-update position.
REQ-018 LOCK SHALL last exactly one cycle with lock=1, then return to IDLE; a spawn_req during LOCK SHALL be ignored.
REQ-019 sq_x SHALL equal X_MIN+STEP*col and sq_y SHALL equal Y_MIN+STEP*row, both registered and updated in the same cycle as col/row; no combinational input-to-output path.
REQ-020 active SHALL be 1 exactly in FALL; game_over SHALL be 1 exactly in OVER.
REQ-021 col SHALL never exceed COLS-1 and row SHALL never exceed ROWS-1; no wrap-around.

Reset
REQ-022 rst SHALL asynchronously force state=IDLE, col=SPAWN_COL, row=0, sq_x=320, sq_y=60, active=0, lock=0, game_over=0.
REQ-023 rst asserted mid-FALL or in OVER SHALL abandon the piece with no lock pulse.
REQ-024 Reset release SHALL take effect on the next clk rising edge; the first spawn is accepted on that edge.

Configuration
REQ-025 Macro HARD_DROP_EN SHALL select hard-drop support.
REQ-026 With HARD_DROP_EN defined: drop in FALL SHALL latch drop mode; every FALL cycle SHALL then be a step event and lateral moves SHALL be ignored until LOCK; drop mode SHALL be cleared on LOCK and by rst.
REQ-027 Without HARD_DROP_EN: drop SHALL be ignored and no drop-mode state SHALL exist.

Verification
REQ-028 Reset then spawn_req=1, spawn_blocked=0 -> next cycle active=1, col=4, row=0, sq_x=320, sq_y=60.
REQ-029 In FALL at col=0, pulse move_left -> col stays 0; pulse move_right three times -> col=3, sq_x=300.
REQ-030 From row 0, apply 20 ticks with coll_below=0 -> row=20, sq_y=460; a 21st tick -> lock=1 for exactly one cycle, then IDLE.
REQ-031 At row=5, tick with coll_below=1 and move_right=1 at col=4 -> col=5, row=5, lock pulse next cycle.
REQ-032 spawn_req with spawn_blocked=1 -> game_over=1, held through further spawn_req and tick inputs until rst.
REQ-033 HARD_DROP_EN defined, drop at row 2 with no collisions -> row increments every cycle, reaching 20 after 18 cycles, then lock; rst asserted at row 10 -> immediate IDLE, row=0, no lock.

Source files
------------

// File: rtl/piece_fall_ctrl.sv
// Falling-piece position controller: spawn, lateral moves, gravity steps, lock and game-over.
// Optional hard-drop support is enabled by defining HARD_DROP_EN.
module piece_fall_ctrl #(
  parameter int X_MIN     = 240,
  parameter int Y_MIN     = 60,
  parameter int STEP      = 20,
  parameter int COLS      = 10,
  parameter int ROWS      = 21,
  parameter int SPAWN_COL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spawn_req,
  input  logic       spawn_blocked,
  input  logic       tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       drop,
  input  logic       coll_left,
  input  logic       coll_right,
  input  logic       coll_below,
  output logic [9:0] sq_x,
  output logic [9:0] sq_y,
  output logic [4:0] col,
  output logic [4:0] row,
  output logic       active,
  output logic       lock,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, FALL, LOCK, OVER} state_t;

  state_t     state, state_nxt;
  logic [4:0] col_nxt, row_nxt;
  logic       step_ev, lat_ok;

`ifdef HARD_DROP_EN
  logic drop_mode, drop_mode_nxt;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
`ifdef HARD_DROP_EN
    // The cycle that requests the drop already counts as a step.
    step_ev       = tick | drop_mode | drop;
    lat_ok        = ~(drop_mode | drop);
    drop_mode_nxt = 1'b0;
`else
    step_ev = tick;
    lat_ok  = 1'b1;
`endif
    case (state)
      IDLE: begin
        if (spawn_req) begin
          if (spawn_blocked) begin
            state_nxt = OVER;
          end else begin
            state_nxt = FALL;
            col_nxt   = 5'(SPAWN_COL);
            row_nxt   = '0;
          end
        end
      end
      FALL: begin
        if (lat_ok && move_left && !move_right && col != '0 && !coll_left)
          col_nxt = col - 5'd1;
        else if (lat_ok && move_right && !move_left && int'(col) < COLS - 1 && !coll_right)
          col_nxt = col + 5'd1;
        if (step_ev) begin
          if (int'(row) < ROWS - 1 && !coll_below)
            row_nxt = row + 5'd1;
          else
            state_nxt = LOCK;
        end
`ifdef HARD_DROP_EN
        drop_mode_nxt = (state_nxt == FALL) && (drop_mode || drop);
`endif
      end
      LOCK:    state_nxt = IDLE;
      default: state_nxt = OVER;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col       <= 5'(SPAWN_COL);
      row       <= '0;
      sq_x      <= 10'(X_MIN + STEP * SPAWN_COL);
      sq_y      <= 10'(Y_MIN);
      active    <= 1'b0;
      lock      <= 1'b0;
      game_over <= 1'b0;
`ifdef HARD_DROP_EN
      drop_mode <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      // Pixel coordinates come from the next-state position so they track col/row exactly.
      sq_x      <= 10'(X_MIN + STEP * int'(col_nxt));
      sq_y      <= 10'(Y_MIN + STEP * int'(row_nxt));
      active    <= (state_nxt == FALL);
      lock      <= (state_nxt == LOCK);
      game_over <= (state_nxt == OVER);
`ifdef HARD_DROP_EN
      drop_mode <= drop_mode_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_piece_fall_ctrl.sv
// Self-checking bench for piece_fall_ctrl: directed scenarios then random stimulus vs a behavioural model.
module tb_piece_fall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spawn_req = 1'b0, spawn_blocked = 1'b0, tick = 1'b0;
  logic       move_left = 1'b0, move_right = 1'b0, drop = 1'b0;
  logic       coll_left = 1'b0, coll_right = 1'b0, coll_below = 1'b0;
  logic [9:0] sq_x, sq_y;
  logic [4:0] col, row;
  logic       active, lock, game_over;

  int total = 0;
  int bad   = 0;

  typedef enum {M_IDLE, M_FALL, M_LOCK, M_OVER} mst_t;
  mst_t m_st  = M_IDLE;
  int   m_col = 4;
  int   m_row = 0;
  bit   m_drop = 1'b0;

  always #5 clk = ~clk;

  piece_fall_ctrl dut (
    .clk(clk), .rst(rst), .spawn_req(spawn_req), .spawn_blocked(spawn_blocked),
    .tick(tick), .move_left(move_left), .move_right(move_right), .drop(drop),
    .coll_left(coll_left), .coll_right(coll_right), .coll_below(coll_below),
    .sq_x(sq_x), .sq_y(sq_y), .col(col), .row(row),
    .active(active), .lock(lock), .game_over(game_over)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("col", 32'(col), m_col);
    chk("row", 32'(row), m_row);
    chk("sq_x", 32'(sq_x), 240 + 20 * m_col);
    chk("sq_y", 32'(sq_y), 60 + 20 * m_row);
    chk("active", 32'(active), (m_st == M_FALL) ? 1 : 0);
    chk("lock", 32'(lock), (m_st == M_LOCK) ? 1 : 0);
    chk("game_over", 32'(game_over), (m_st == M_OVER) ? 1 : 0);
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_col = 4; m_row = 0; m_drop = 1'b0;
  endtask

  // One clock edge of the game rules, using the inputs presented during that cycle.
  task automatic model_edge();
    bit dropping, stepping;
    case (m_st)
      M_IDLE: if (spawn_req) begin
        if (spawn_blocked) m_st = M_OVER;
        else begin m_st = M_FALL; m_col = 4; m_row = 0; end
      end
      M_FALL: begin
        dropping = 1'b0;
`ifdef HARD_DROP_EN
        dropping = m_drop || drop;
`endif
        stepping = tick || dropping;
        if (!dropping && move_left != move_right) begin
          if (move_left && m_col > 0 && !coll_left) m_col = m_col - 1;
          if (move_right && m_col < 9 && !coll_right) m_col = m_col + 1;
        end
        if (stepping) begin
          if (m_row < 20 && !coll_below) m_row = m_row + 1;
          else m_st = M_LOCK;
        end
        m_drop = (m_st == M_FALL) && dropping;
      end
      M_LOCK: m_st = M_IDLE;
      default: m_st = M_OVER;
    endcase
  endtask

  task automatic clr();
    spawn_req = 0; spawn_blocked = 0; tick = 0; move_left = 0; move_right = 0;
    drop = 0; coll_left = 0; coll_right = 0; coll_below = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, releases on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    clr();
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clr();
    do_reset();
    chk("rst_sq_x", 32'(sq_x), 320);
    chk("rst_sq_y", 32'(sq_y), 60);

    // Spawn on the first edge after reset release
    spawn_req = 1; step(); clr();
    chk("spawn_active", 32'(active), 1);
    chk("spawn_col", 32'(col), 4);
    chk("spawn_sq_x", 32'(sq_x), 320);

    // Lateral moves and wall clamp
    move_left = 1; repeat (5) step(); clr();
    chk("left_wall", 32'(col), 0);
    move_right = 1; repeat (3) step(); clr();
    chk("right3_col", 32'(col), 3);
    chk("right3_sq_x", 32'(sq_x), 300);
    move_left = 1; move_right = 1; step(); clr();
    chk("both_moves", 32'(col), 3);
    move_left = 1; coll_left = 1; step(); clr();
    chk("coll_left_hold", 32'(col), 3);

    // Gravity to the floor, lock, spawn ignored during lock
    tick = 1; repeat (20) step();
    chk("floor_row", 32'(row), 20);
    chk("floor_sq_y", 32'(sq_y), 460);
    step(); clr();
    chk("floor_lock", 32'(lock), 1);
    spawn_req = 1; step(); clr();
    chk("lock_one_cycle", 32'(lock), 0);
    chk("lock_spawn_ignored", 32'(active), 0);

    // Collision below with simultaneous lateral move
    spawn_req = 1; step(); clr();
    tick = 1; repeat (5) step();
    move_right = 1; coll_below = 1; step(); clr();
    chk("cb_col", 32'(col), 5);
    chk("cb_row", 32'(row), 5);
    chk("cb_lock", 32'(lock), 1);
    step();

    // Mid-fall reset abandons the piece
    spawn_req = 1; step(); clr();
    tick = 1; repeat (3) step(); clr();
    do_reset();
    chk("midfall_rst_lock", 32'(lock), 0);
    step();
    chk("midfall_after_lock", 32'(lock), 0);

    // Blocked spawn is sticky game over
    spawn_req = 1; spawn_blocked = 1; step(); clr();
    chk("over_set", 32'(game_over), 1);
    spawn_req = 1; tick = 1; repeat (4) step(); clr();
    chk("over_sticky", 32'(game_over), 1);
    do_reset();
    chk("over_cleared", 32'(game_over), 0);

`ifdef HARD_DROP_EN
    spawn_req = 1; step(); clr();
    tick = 1; repeat (2) step(); clr();
    drop = 1; step(); clr();
    move_left = 1; repeat (17) step(); clr();
    chk("drop_row20", 32'(row), 20);
    chk("drop_no_lateral", 32'(col), 4);
    step();
    chk("drop_lock", 32'(lock), 1);
    step();
    spawn_req = 1; step(); clr();
    drop = 1; step(); clr();
    repeat (9) step();
    chk("drop_row10", 32'(row), 10);
    do_reset();
    chk("drop_rst_row", 32'(row), 0);
    chk("drop_rst_lock", 32'(lock), 0);
    step();
    chk("drop_rst_idle", 32'(active), 0);
`endif

    // Random play against the model
    for (int i = 0; i < 600; i++) begin
      if ((m_st == M_OVER && $urandom_range(0, 3) == 0) || $urandom_range(0, 150) == 0) begin
        do_reset();
      end else begin
        spawn_req     = 1'($urandom_range(0, 1));
        spawn_blocked = ($urandom_range(0, 15) == 0);
        tick          = 1'($urandom_range(0, 1));
        move_left     = 1'($urandom_range(0, 1));
        move_right    = 1'($urandom_range(0, 1));
        drop          = ($urandom_range(0, 20) == 0);
        coll_left     = ($urandom_range(0, 3) == 0);
        coll_right    = ($urandom_range(0, 3) == 0);
        coll_below    = ($urandom_range(0, 9) == 0);
        step();
      end
    end
    clr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
